config_chain_loader: RTL and testbench



---
 rtl/config_chain_if.sv | 32 +++
 rtl/config_chain_loader.sv | 182 ++++++++++++++++++
 tb/tb_config_chain_loader.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/config_chain_if.sv
// Bundles the bitstream source handshake, chain-side serial signals and status
// outputs of the config chain loader. The slave side is the loader itself.
interface config_chain_if #(
    parameter int WORD_W = 32
);
    logic              start;
    logic              abort;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              cen;
    logic              shift_data;
    logic              chain_tail;
    logic              set_out;
    logic [WORD_W-1:0] rb_data;
    logic              rb_valid;
    logic              busy;
    logic              done;
    logic              aborted;

    modport slave (
        input  start, abort, cfg_data, cfg_valid, chain_tail,
        output cfg_ready, cen, shift_data, set_out, rb_data, rb_valid,
               busy, done, aborted
    );

    modport master (
        output start, abort, cfg_data, cfg_valid, chain_tail,
        input  cfg_ready, cen, shift_data, set_out, rb_data, rb_valid,
               busy, done, aborted
    );
endinterface

// File: rtl/config_chain_loader.sv
// Streams bitstream words LSB-first into a serial config chain, strobes set once
// CHAIN_LEN bits are in, and packs bits returning from the chain tail into readback words.
module config_chain_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 40,
    parameter int CNT_W     = 16
) (
    input logic           clk,
    input logic           rst_n,
    config_chain_if.slave bus
);

    localparam int               IDX_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(WORD_W - 1);

    if (CHAIN_LEN < 1) begin : g_len_check
        $error("config_chain_loader: CHAIN_LEN must be at least 1");
    end
    if (CNT_W < 31 && (32'sd1 << CNT_W) <= CHAIN_LEN) begin : g_cnt_check
        $error("config_chain_loader: CNT_W too narrow for CHAIN_LEN");
    end

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        SET,
        FINISH
    } state_e;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  widx_q, widx_d;
    logic [IDX_W-1:0]  ridx_q, ridx_d;
    logic [CNT_W-1:0]  bits_q, bits_d;
    logic [WORD_W-1:0] rb_shift_q, rb_shift_d;
    logic [WORD_W-1:0] rb_data_q, rb_data_d;
    logic              rb_valid_q, rb_valid_d;
    logic              aborted_q, aborted_d;

    logic              abort_take;
    logic              last_bit;
    logic              word_end;
    logic              rb_flush;
    logic [WORD_W-1:0] rb_word;

    assign abort_take = bus.abort && (state_q != IDLE);
    assign last_bit   = (bits_q == LAST_BIT);
    assign word_end   = (widx_q == WORD_LAST);
    // The readback word closes on a full word or on the very last chain bit.
    assign rb_flush   = (ridx_q == WORD_LAST) || last_bit;

    always_comb begin
        rb_word         = rb_shift_q;
        rb_word[ridx_q] = bus.chain_tail;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned and infers a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = FETCH;
            FETCH:   if (bus.cfg_valid) state_d = SHIFT;
            SHIFT: begin
                if (last_bit) begin
                    state_d = SET;
                end else if (word_end) begin
                    state_d = FETCH;
                end
            end
            SET:     state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_take) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        bus.cfg_ready  = 1'b0;
        bus.cen        = 1'b0;
        bus.shift_data = 1'b0;
        bus.set_out    = 1'b0;
        bus.done       = 1'b0;
        unique case (state_q)
            FETCH:  bus.cfg_ready = 1'b1;
            SHIFT: begin
                bus.cen        = 1'b1;
                bus.shift_data = word_q[widx_q];
            end
            SET:    bus.set_out = 1'b1;
            FINISH: bus.done = 1'b1;
            default: ;
        endcase
        bus.busy = (state_q != IDLE);
    end

    assign bus.rb_data  = rb_data_q;
    assign bus.rb_valid = rb_valid_q;
    assign bus.aborted  = aborted_q;

    always_comb begin
        word_d     = word_q;
        widx_d     = widx_q;
        ridx_d     = ridx_q;
        bits_d     = bits_q;
        rb_shift_d = rb_shift_q;
        rb_data_d  = rb_data_q;
        rb_valid_d = 1'b0;
        aborted_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                bits_d     = '0;
                widx_d     = '0;
                ridx_d     = '0;
                rb_shift_d = '0;
            end
            FETCH: begin
                if (bus.cfg_valid) begin
                    word_d = bus.cfg_data;
                    widx_d = '0;
                end
            end
            SHIFT: begin
                bits_d = bits_q + CNT_W'(1);
                widx_d = widx_q + IDX_W'(1);
                if (rb_flush) begin
                    rb_data_d  = rb_word;
                    rb_valid_d = 1'b1;
                    rb_shift_d = '0;
                    ridx_d     = '0;
                end else begin
                    rb_shift_d = rb_word;
                    ridx_d     = ridx_q + IDX_W'(1);
                end
            end
            default: ;
        endcase
        // An abort never publishes the partially assembled readback word.
        if (abort_take) begin
            aborted_d  = 1'b1;
            rb_valid_d = 1'b0;
            rb_data_d  = rb_data_q;
        end
    end

    // NOTE: the word and readback buffers are reset as well, so a reset mid-load
    // leaves no stale data visible on rb_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q     <= '0;
            widx_q     <= '0;
            ridx_q     <= '0;
            bits_q     <= '0;
            rb_shift_q <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            word_q     <= word_d;
            widx_q     <= widx_d;
            ridx_q     <= ridx_d;
            bits_q     <= bits_d;
            rb_shift_q <= rb_shift_d;
            rb_data_q  <= rb_data_d;
            rb_valid_q <= rb_valid_d;
            aborted_q  <= aborted_d;
        end
    end

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: a 40-bit chain model on the serial port, a table of
// directed loads, hand-written abort/reset/ignored-input sequences and random loads.
module tb_config_chain_loader;

    localparam int WW = 32;
    localparam int CL = 40;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    config_chain_if #(.WORD_W(WW)) bus ();

    config_chain_loader #(.WORD_W(WW), .CHAIN_LEN(CL), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Chain model: bits enter at index 0 and leave from the top index.
    logic [CL-1:0] chain_q = '1;
    assign bus.chain_tail = chain_q[CL-1];
    always @(posedge clk) if (bus.cen) chain_q <= {chain_q[CL-2:0], bus.shift_data};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cen = 0, n_hs = 0, n_set = 0, n_done = 0, n_abt = 0, n_rdy = 0, n_ovl = 0;
    int set_cyc = 0, done_cyc = 0;
    bit sq[$];
    logic [WW-1:0] rbq[$];

    always @(negedge clk) begin
        if (bus.cen) begin
            n_cen <= n_cen + 1;
            sq.push_back(bus.shift_data);
        end
        if (bus.cfg_valid && bus.cfg_ready) n_hs <= n_hs + 1;
        if (bus.cfg_ready) n_rdy <= n_rdy + 1;
        if (bus.cfg_ready && bus.cen) n_ovl <= n_ovl + 1;
        if (bus.set_out) begin
            n_set   <= n_set + 1;
            set_cyc <= cyc;
        end
        if (bus.done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
        if (bus.aborted) n_abt <= n_abt + 1;
        if (bus.rb_valid) rbq.push_back(bus.rb_data);
    end

    typedef struct {
        int cen, hs, set, done, abt, rdy, ovl, rb, sq;
    } snap_t;

    typedef struct {
        logic [WW-1:0] w0, w1;
        int            s0, s1;
        bit            early;
        int            dly;
        logic [WW-1:0] er0, er1;
    } vec_t;

    int            total = 0;
    int            bad = 0;
    logic [CL-1:0] prev_stream;
    bit            rb_known;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic snap_t take_snap();
        snap_t s;
        s.cen = n_cen; s.hs = n_hs; s.set = n_set; s.done = n_done; s.abt = n_abt;
        s.rdy = n_rdy; s.ovl = n_ovl; s.rb = rbq.size(); s.sq = sq.size();
        return s;
    endfunction

    // Bits enter the chain LSB first, words in arrival order, first CL bits only.
    function automatic logic [CL-1:0] stream_of(input logic [WW-1:0] w0, input logic [WW-1:0] w1);
        logic [2*WW-1:0] cat;
        cat = {w1, w0};
        return cat[CL-1:0];
    endfunction

    // Start cycle -> set cycle: each word costs one fetch cycle, its stall and its bits.
    function automatic int exp_delay(input int s0, input int s1);
        int bits0;
        bits0 = (CL < WW) ? CL : WW;
        return 1 + (1 + s0 + bits0) + (1 + s1 + (CL - bits0));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(output int st);
        bus.start = 1'b1;
        st = cyc;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic feed_word(input logic [WW-1:0] w, input int stall, input bit early);
        int n;
        n = 0;
        if (early) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_data  = w;
        end
        while (!bus.cfg_ready && n < 300) begin
            tick();
            n++;
        end
        check("fetch reached", 64'(bus.cfg_ready), 64'(1));
        if (!early) repeat (stall) tick();
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = w;
        tick();
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = $urandom;
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (n_done == d0 && n < 400) begin
            tick();
            n++;
        end
    endtask

    task automatic check_load(input string tag, input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                              input int rdy_exp, input int st, input int dly, input snap_t b,
                              input bit has_rb, input logic [WW-1:0] er0, input logic [WW-1:0] er1);
        logic [CL-1:0] act;
        act = '0;
        for (int i = 0; i < CL; i++) act[i] = (b.sq + i < sq.size()) ? sq[b.sq + i] : 1'b0;
        check({tag, " cen count"}, 64'(n_cen - b.cen), 64'(CL));
        check({tag, " handshakes"}, 64'(n_hs - b.hs), 64'(2));
        check({tag, " set count"}, 64'(n_set - b.set), 64'(1));
        check({tag, " done count"}, 64'(n_done - b.done), 64'(1));
        check({tag, " set to done"}, 64'(done_cyc - set_cyc), 64'(1));
        check({tag, " set delay"}, 64'(set_cyc - st), 64'(dly));
        check({tag, " ready cycles"}, 64'(n_rdy - b.rdy), 64'(rdy_exp));
        check({tag, " ready with cen"}, 64'(n_ovl - b.ovl), 64'(0));
        check({tag, " shift stream"}, 64'(act), 64'(stream_of(w0, w1)));
        check({tag, " rb count"}, 64'(rbq.size() - b.rb), 64'(2));
        if (has_rb && rbq.size() >= b.rb + 2) begin
            check({tag, " rb word0"}, 64'(rbq[b.rb]), 64'(er0));
            check({tag, " rb word1"}, 64'(rbq[b.rb + 1]), 64'(er1));
        end
        check({tag, " busy after"}, 64'(bus.busy), 64'(0));
        check({tag, " aborted count"}, 64'(n_abt - b.abt), 64'(0));
    endtask

    task automatic run_case(input string tag, input vec_t v, input bit has_rb);
        snap_t b;
        int    st;
        b = take_snap();
        start_load(st);
        feed_word(v.w0, v.s0, 1'b0);
        feed_word(v.w1, v.s1, v.early);
        wait_done(b.done);
        repeat (2) tick();
        check_load(tag, v.w0, v.w1, 2 + v.s0 + v.s1, st, v.dly, b, has_rb, v.er0, v.er1);
        prev_stream = stream_of(v.w0, v.w1);
        rb_known    = 1'b1;
    endtask

    function automatic vec_t rand_vec(input bit allow_early);
        vec_t v;
        v.w0    = $urandom;
        v.w1    = $urandom;
        v.s0    = $urandom_range(0, 3);
        v.early = allow_early && ($urandom_range(0, 3) == 0);
        v.s1    = v.early ? 0 : $urandom_range(0, 3);
        v.dly   = exp_delay(v.s0, v.s1);
        v.er0   = prev_stream[WW-1:0];
        v.er1   = WW'(prev_stream >> WW);
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        vec_t  tbl[4];
        vec_t  v;
        snap_t b, b2;
        int    st, n;

        tbl[0] = '{32'hA5A5_0F0F, 32'h0000_00C3, 0, 0, 1'b0, 43, 32'hFFFF_FFFF, 32'h0000_00FF};
        tbl[1] = '{32'hA5A5_0F0F, 32'h0000_00C3, 0, 5, 1'b0, 48, 32'hA5A5_0F0F, 32'h0000_00C3};
        tbl[2] = '{32'hFFFF_FFFF, 32'hFFFF_FF00, 2, 0, 1'b0, 45, 32'hA5A5_0F0F, 32'h0000_00C3};
        tbl[3] = '{32'h0000_0000, 32'h1234_56FF, 1, 0, 1'b1, 44, 32'hFFFF_FFFF, 32'h0000_0000};

        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = '0;
        rst_n         = 1'b1;
        rb_known      = 1'b0;
        prev_stream   = '1;
        #2 rst_n = 1'b0;
        #1;
        check("reset outputs", 64'({bus.cfg_ready, bus.cen, bus.shift_data, bus.set_out,
                                    bus.rb_valid, bus.busy, bus.done, bus.aborted}), 64'(0));
        check("reset rb_data", 64'(bus.rb_data), 64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick();
        repeat (3) tick();
        check("idle busy", 64'(bus.busy), 64'(0));

        for (int i = 0; i < 4; i++) run_case($sformatf("vec%0d", i), tbl[i], 1'b1);

        // abort in IDLE is ignored, then start pulsed mid-SHIFT is ignored
        b2 = take_snap();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        repeat (2) tick();
        check("idle abort pulse", 64'(n_abt - b2.abt), 64'(0));
        check("idle abort busy", 64'(bus.busy), 64'(0));
        v = rand_vec(1'b0);
        v.s0 = 0; v.s1 = 0; v.dly = exp_delay(0, 0);
        b = take_snap();
        start_load(st);
        feed_word(v.w0, 0, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        feed_word(v.w1, 0, 1'b0);
        wait_done(b.done);
        repeat (4) tick();
        check_load("restart", v.w0, v.w1, 2, st, v.dly, b, rb_known, v.er0, v.er1);
        prev_stream = stream_of(v.w0, v.w1);

        // abort at bit 20
        b = take_snap();
        start_load(st);
        feed_word($urandom, 0, 1'b0);
        n = 0;
        while (n_cen - b.cen < 20 && n < 100) begin
            tick();
            n++;
        end
        check("abort reached bit 20", 64'(n_cen - b.cen), 64'(20));
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort cen", 64'(bus.cen), 64'(0));
        check("abort busy", 64'(bus.busy), 64'(0));
        check("abort pulse", 64'(bus.aborted), 64'(1));
        repeat (3) tick();
        check("abort set count", 64'(n_set - b.set), 64'(0));
        check("abort done count", 64'(n_done - b.done), 64'(0));
        check("abort aborted count", 64'(n_abt - b.abt), 64'(1));
        check("abort rb count", 64'(rbq.size() - b.rb), 64'(0));
        rb_known = 1'b0;
        run_case("post abort", rand_vec(1'b1), 1'b0);

        // reset mid-load at bit 35
        b = take_snap();
        start_load(st);
        feed_word($urandom, 0, 1'b0);
        feed_word($urandom, 0, 1'b0);
        n = 0;
        while (n_cen - b.cen < 35 && n < 100) begin
            tick();
            n++;
        end
        check("reset reached bit 35", 64'(n_cen - b.cen), 64'(35));
        rst_n = 1'b0;
        #1;
        check("midload reset outputs", 64'({bus.cfg_ready, bus.cen, bus.shift_data, bus.set_out,
                                            bus.rb_valid, bus.busy, bus.done, bus.aborted}), 64'(0));
        check("midload reset rb_data", 64'(bus.rb_data), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        b2 = take_snap();
        repeat (10) tick();
        check("post reset quiet cen", 64'(n_cen - b2.cen), 64'(0));
        check("post reset quiet hs", 64'(n_hs - b2.hs), 64'(0));
        check("post reset quiet set/done", 64'((n_set - b2.set) + (n_done - b2.done)), 64'(0));
        check("post reset busy", 64'(bus.busy), 64'(0));
        rb_known = 1'b0;
        run_case("post reset", rand_vec(1'b1), 1'b0);

        for (int i = 0; i < 30; i++) run_case($sformatf("rand%0d", i), rand_vec(1'b1), rb_known);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
